ravan_axil_slave: RTL and testbench

- Parametrised AXI4-Lite slave front-end for the RAVAN crypto core, replacing the fixed 64-bit write-then-read sequencer.
- Presents a memory-mapped register file: control, status, core address, data in, data out and a multi-word key.
- Runs the core for a programmable latency, then captures the result and raises done/irq.
- AW/W/B and AR/R channels are independent, fully handshaked, and report OKAY/SLVERR.

---
 rtl/ravan_axil_pkg.sv | 36 +++
 rtl/ravan_op_sequencer.sv | 89 ++++++++
 rtl/ravan_axil_slave.sv | 230 +++++++++++++++++++++++
 tb/tb_ravan_axil_slave.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ravan_axil_pkg.sv
// Shared constants and types for the RAVAN AXI4-Lite slave front-end.
package ravan_axil_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned IDX_CTRL      = 32'd0;
  localparam int unsigned IDX_STATUS    = 32'd1;
  localparam int unsigned IDX_CORE_ADDR = 32'd2;
  localparam int unsigned IDX_DATA_IN   = 32'd3;
  localparam int unsigned IDX_DATA_OUT  = 32'd4;
  localparam int unsigned KEY_BASE      = 32'd8;

  localparam int unsigned CTRL_START   = 32'd0;
  localparam int unsigned CTRL_ENC_SEL = 32'd1;
  localparam int unsigned CTRL_MEM_SEL = 32'd2;
  localparam int unsigned CTRL_IRQ_EN  = 32'd3;

  localparam int unsigned STAT_BUSY = 32'd0;
  localparam int unsigned STAT_DONE = 32'd1;
  localparam int unsigned STAT_ERR  = 32'd2;

  typedef enum logic [2:0] {
    REG_CTRL      = 3'd0,
    REG_STATUS    = 3'd1,
    REG_CORE_ADDR = 3'd2,
    REG_DATA_IN   = 3'd3,
    REG_DATA_OUT  = 3'd4,
    REG_KEY       = 3'd5,
    REG_NONE      = 3'd6
  } reg_sel_e;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_e;
endpackage

// File: rtl/ravan_op_sequencer.sv
// IDLE/RUN sequencer: fires the core, waits CORE_LAT cycles, captures result and error.
module ravan_op_sequencer
  import ravan_axil_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int CORE_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_req,
  input  logic [DATA_W-1:0] core_data_out,
  input  logic              core_error,
  output logic              core_start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] data_out
);
  localparam int CNT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CORE_LAT - 1);

  seq_state_e        state_r, state_nx_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
  logic              launch_s, capture_s;
  logic              core_start_r, done_r, err_r;
  logic [DATA_W-1:0] data_out_r;

  // State, counter and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= SEQ_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      core_start_r <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      data_out_r   <= {DATA_W{1'b0}};
    end else begin
      state_r      <= state_nx_s;
      cnt_r        <= cnt_nx_s;
      core_start_r <= launch_s;
      if (launch_s) begin
        done_r <= 1'b0;
        err_r  <= 1'b0;
      end else if (capture_s) begin
        done_r     <= 1'b1;
        err_r      <= core_error;
        data_out_r <= core_data_out;
      end
    end
  end

  // Next-state and counter decode
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    launch_s   = 1'b0;
    capture_s  = 1'b0;
    case (state_r)
      SEQ_IDLE: begin
        if (start_req) begin
          state_nx_s = SEQ_RUN;
          cnt_nx_s   = CNT_LOAD;
          launch_s   = 1'b1;
        end else begin
          state_nx_s = SEQ_IDLE;
        end
      end
      SEQ_RUN: begin
        if (cnt_r != {CNT_W{1'b0}}) begin
          cnt_nx_s = cnt_r - CNT_W'(1);
        end else begin
          capture_s  = 1'b1;
          state_nx_s = SEQ_IDLE;
        end
      end
      default: state_nx_s = SEQ_IDLE;
    endcase
  end

  // Outputs derived from registered state
  always_comb begin
    busy = (state_r == SEQ_RUN);
  end

  assign core_start = core_start_r;
  assign done       = done_r;
  assign err        = err_r;
  assign data_out   = data_out_r;
endmodule

// File: rtl/ravan_axil_slave.sv
// AXI4-Lite register front-end for the RAVAN crypto core: independent write/read
// channels over CTRL/STATUS/CORE_ADDR/DATA_IN/DATA_OUT/KEY registers.
module ravan_axil_slave
  import ravan_axil_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int KEY_W       = 512,
  parameter int ADDR_W      = 16,
  parameter int CORE_ADDR_W = 32,
  parameter int CORE_LAT    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [ADDR_W-1:0]      awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [DATA_W/8-1:0]    wstrb,
  output logic                   bvalid,
  input  logic                   bready,
  output logic [1:0]             bresp,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [ADDR_W-1:0]      araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [DATA_W-1:0]      rdata,
  output logic [1:0]             rresp,
  output logic                   core_start,
  output logic                   core_enc_sel,
  output logic                   core_mem_sel,
  output logic [CORE_ADDR_W-1:0] core_addr,
  output logic [DATA_W-1:0]      core_data_in,
  output logic [KEY_W-1:0]       core_key,
  input  logic [DATA_W-1:0]      core_data_out,
  input  logic                   core_error,
  output logic                   irq
);
  localparam int STRB_W    = DATA_W / 8;
  localparam int ADDR_LSB  = $clog2(STRB_W);
  localparam int KEY_WORDS = KEY_W / DATA_W;
  localparam int KIDX_W    = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam logic [ADDR_W-1:0] IX_CTRL      = ADDR_W'(IDX_CTRL);
  localparam logic [ADDR_W-1:0] IX_STATUS    = ADDR_W'(IDX_STATUS);
  localparam logic [ADDR_W-1:0] IX_CORE_ADDR = ADDR_W'(IDX_CORE_ADDR);
  localparam logic [ADDR_W-1:0] IX_DATA_IN   = ADDR_W'(IDX_DATA_IN);
  localparam logic [ADDR_W-1:0] IX_DATA_OUT  = ADDR_W'(IDX_DATA_OUT);
  localparam logic [ADDR_W-1:0] IX_KEY       = ADDR_W'(KEY_BASE);
  localparam logic [ADDR_W-1:0] IX_KEY_END   = ADDR_W'(KEY_BASE + KEY_WORDS);
  localparam logic [DATA_W-1:0] CA_MASK      = DATA_W'({CORE_ADDR_W{1'b1}});

  function automatic reg_sel_e decode(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] idx;
    reg_sel_e          sel;
    idx = addr >> ADDR_LSB;
    if      (idx == IX_CTRL)                        sel = REG_CTRL;
    else if (idx == IX_STATUS)                      sel = REG_STATUS;
    else if (idx == IX_CORE_ADDR)                   sel = REG_CORE_ADDR;
    else if (idx == IX_DATA_IN)                     sel = REG_DATA_IN;
    else if (idx == IX_DATA_OUT)                    sel = REG_DATA_OUT;
    else if (idx >= IX_KEY && idx < IX_KEY_END)     sel = REG_KEY;
    else                                            sel = REG_NONE;
    return sel;
  endfunction

  function automatic logic [KIDX_W-1:0] key_idx(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = (addr >> ADDR_LSB) - IX_KEY;
    return off[KIDX_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                              input logic [DATA_W-1:0] new_v,
                                              input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      else         res[8*b +: 8] = old_v[8*b +: 8];
    end
    return res;
  endfunction

  logic                 rdy_en_r;
  logic                 aw_held_r, w_held_r, bvalid_r, rvalid_r;
  logic [ADDR_W-1:0]    awaddr_r;
  logic [DATA_W-1:0]    wdata_r, rdata_r;
  logic [STRB_W-1:0]    wstrb_r;
  logic [1:0]           bresp_r, rresp_r;
  logic [2:0]           ctrl_r;
  logic [DATA_W-1:0]    core_addr_r, data_in_r;
  logic [DATA_W-1:0]    key_r [KEY_WORDS];
  logic                 commit_s, wr_err_s, wr_ok_s, start_req_s;
  reg_sel_e             wr_sel_s;
  logic [DATA_W-1:0]    rd_data_s;
  logic [1:0]           rd_resp_s;
  logic                 busy_s, done_s, err_s;
  logic [DATA_W-1:0]    data_out_s;

  assign awready  = rdy_en_r && !aw_held_r && !bvalid_r;
  assign wready   = rdy_en_r && !w_held_r && !bvalid_r;
  assign arready  = rdy_en_r && !rvalid_r;
  assign commit_s = aw_held_r && w_held_r;
  assign wr_ok_s  = commit_s && !wr_err_s;
  assign start_req_s = wr_ok_s && (wr_sel_s == REG_CTRL) && wstrb_r[0] && wdata_r[CTRL_START];

  // Write legality: RO/unmapped always rejected, core-facing registers locked while busy
  always_comb begin
    wr_sel_s = decode(awaddr_r);
    wr_err_s = 1'b0;
    case (wr_sel_s)
      REG_CTRL:                             wr_err_s = busy_s && wstrb_r[0];
      REG_CORE_ADDR, REG_DATA_IN, REG_KEY:  wr_err_s = busy_s;
      default:                              wr_err_s = 1'b1;
    endcase
  end

  // AW/W capture, commit and B response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en_r  <= 1'b0;
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      awaddr_r  <= {ADDR_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
      wstrb_r   <= {STRB_W{1'b0}};
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      rdy_en_r <= 1'b1;
      if (awvalid && awready) begin
        aw_held_r <= 1'b1;
        awaddr_r  <= awaddr;
      end
      if (wvalid && wready) begin
        w_held_r <= 1'b1;
        wdata_r  <= wdata;
        wstrb_r  <= wstrb;
      end
      if (commit_s) begin
        aw_held_r <= 1'b0;
        w_held_r  <= 1'b0;
        bvalid_r  <= 1'b1;
        bresp_r   <= wr_err_s ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_r && bready) begin
        bvalid_r <= 1'b0;
      end
    end
  end

  // Register file update on an accepted write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_r      <= 3'b000;
      core_addr_r <= {DATA_W{1'b0}};
      data_in_r   <= {DATA_W{1'b0}};
      for (int k = 0; k < KEY_WORDS; k++) key_r[k] <= {DATA_W{1'b0}};
    end else if (wr_ok_s) begin
      case (wr_sel_s)
        REG_CTRL:      if (wstrb_r[0]) ctrl_r <= wdata_r[CTRL_IRQ_EN:CTRL_ENC_SEL];
        REG_CORE_ADDR: core_addr_r <= merge(core_addr_r, wdata_r, wstrb_r) & CA_MASK;
        REG_DATA_IN:   data_in_r   <= merge(data_in_r, wdata_r, wstrb_r);
        REG_KEY:       key_r[key_idx(awaddr_r)] <= merge(key_r[key_idx(awaddr_r)], wdata_r, wstrb_r);
        default:       ;
      endcase
    end
  end

  // Read data mux; START always reads back as 0
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    rd_resp_s = RESP_OKAY;
    case (decode(araddr))
      REG_CTRL:      rd_data_s = DATA_W'({ctrl_r, 1'b0});
      REG_STATUS:    rd_data_s = DATA_W'({err_s, done_s, busy_s});
      REG_CORE_ADDR: rd_data_s = core_addr_r;
      REG_DATA_IN:   rd_data_s = data_in_r;
      REG_DATA_OUT:  rd_data_s = data_out_s;
      REG_KEY:       rd_data_s = key_r[key_idx(araddr)];
      default:       rd_resp_s = RESP_SLVERR;
    endcase
  end

  // AR handshake registers the R beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_r <= 1'b0;
      rdata_r  <= {DATA_W{1'b0}};
      rresp_r  <= RESP_OKAY;
    end else if (arvalid && arready) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rd_data_s;
      rresp_r  <= rd_resp_s;
    end else if (rvalid_r && rready) begin
      rvalid_r <= 1'b0;
    end
  end

  ravan_op_sequencer #(
    .DATA_W   (DATA_W),
    .CORE_LAT (CORE_LAT)
  ) u_seq (
    .clk           (clk),
    .rst           (rst),
    .start_req     (start_req_s),
    .core_data_out (core_data_out),
    .core_error    (core_error),
    .core_start    (core_start),
    .busy          (busy_s),
    .done          (done_s),
    .err           (err_s),
    .data_out      (data_out_s)
  );

  for (genvar g = 0; g < KEY_WORDS; g++) begin : g_key
    assign core_key[g*DATA_W +: DATA_W] = key_r[g];
  end

  assign bvalid       = bvalid_r;
  assign bresp        = bresp_r;
  assign rvalid       = rvalid_r;
  assign rdata        = rdata_r;
  assign rresp        = rresp_r;
  assign core_enc_sel = ctrl_r[0];
  assign core_mem_sel = ctrl_r[1];
  assign core_addr    = core_addr_r[CORE_ADDR_W-1:0];
  assign core_data_in = data_in_r;
  assign irq          = done_s & ctrl_r[2];
endmodule

// File: tb/tb_ravan_axil_slave.sv
// Directed self-checking bench for ravan_axil_slave (default parameters).
module tb_ravan_axil_slave;
  logic         clk = 1'b0;
  logic         rst;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic [15:0]  awaddr, araddr;
  logic [63:0]  wdata, rdata, core_data_in, core_data_out;
  logic [7:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         arvalid, arready, rvalid, rready;
  logic         core_start, core_enc_sel, core_mem_sel, core_error, irq;
  logic [31:0]  core_addr;
  logic [511:0] core_key, key_exp;

  int tests = 0;
  int failed = 0;
  int start_pulses = 0;

  localparam logic [63:0] CORE_VAL = 64'hDEAD_BEEF_CAFE_F00D;

  ravan_axil_slave dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .core_start(core_start), .core_enc_sel(core_enc_sel), .core_mem_sel(core_mem_sel),
    .core_addr(core_addr), .core_data_in(core_data_in), .core_key(core_key),
    .core_data_out(core_data_out), .core_error(core_error), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (core_start) start_pulses++;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called and returning at a falling edge.
  task automatic axi_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s,
                           output logic [1:0] resp);
    bit aw_ok, w_ok, got_b;
    int n;
    aw_ok = 0; w_ok = 0; got_b = 0; resp = 2'b11;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!(aw_ok && w_ok) && n < 20) begin
      if (awvalid && awready) aw_ok = 1;
      if (wvalid && wready) w_ok = 1;
      @(posedge clk); @(negedge clk);
      if (aw_ok) awvalid = 1'b0;
      if (w_ok) wvalid = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!got_b && n < 20) begin
      if (bvalid) begin got_b = 1; resp = bresp; end
      @(posedge clk); @(negedge clk);
      n++;
    end
    bready = 1'b0;
    if (!got_b) check("write_timeout", 64'(got_b), 64'd1);
  endtask

  task automatic axi_read(input logic [15:0] a, output logic [63:0] d, output logic [1:0] resp);
    bit ar_ok, got_r;
    int n;
    ar_ok = 0; got_r = 0; d = 64'hX; resp = 2'b11;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!ar_ok && n < 20) begin
      if (arready) ar_ok = 1;
      @(posedge clk); @(negedge clk);
      n++;
    end
    arvalid = 1'b0;
    n = 0;
    while (!got_r && n < 20) begin
      if (rvalid) begin got_r = 1; d = rdata; resp = rresp; end
      @(posedge clk); @(negedge clk);
      n++;
    end
    rready = 1'b0;
    if (!got_r) check("read_timeout", 64'(got_r), 64'd1);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [63:0] rd;
    int          p0, hold, acc;

    rst = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    awaddr = 16'h0; araddr = 16'h0; wdata = 64'h0; wstrb = 8'h0;
    core_error = 1'b0; core_data_out = CORE_VAL;
    for (int i = 0; i < 8; i++) key_exp[i*64 +: 64] = 64'(i);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_handshake", 64'({awready, wready, arready, bvalid, rvalid}), 64'd0);
    check("rst_resp_rdata", 64'({bresp, rresp}) | rdata, 64'd0);
    check("rst_core_out", 64'({core_start, irq, core_enc_sel, core_mem_sel}), 64'd0);
    check("rst_core_regs", 64'(core_addr) | core_data_in | 64'(core_key != 512'd0), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // Full operation
    for (int i = 0; i < 8; i++) begin
      axi_write(16'h40 + 16'(8*i), 64'(i), 8'hFF, resp);
      check("key_wr_resp", 64'(resp), 64'd0);
    end
    axi_write(16'h18, 64'h1122_3344_5566_7788, 8'hFF, resp);
    check("din_wr_resp", 64'(resp), 64'd0);
    axi_write(16'h10, 64'h40, 8'hFF, resp);
    check("caddr_wr_resp", 64'(resp), 64'd0);
    p0 = start_pulses;
    axi_write(16'h00, 64'hB, 8'hFF, resp);
    check("ctrl_wr_resp", 64'(resp), 64'd0);
    @(negedge clk);
    axi_read(16'h08, rd, resp);
    check("status_busy_capture_cycle", rd, 64'h1);
    check("start_single_pulse", 64'(start_pulses - p0), 64'd1);
    axi_read(16'h08, rd, resp);
    check("status_done", rd, 64'h2);
    check("irq_set", 64'(irq), 64'd1);
    axi_read(16'h20, rd, resp);
    check("data_out", rd, CORE_VAL);
    axi_read(16'h00, rd, resp);
    check("ctrl_readback", rd, 64'hA);
    check("core_sel", 64'({core_enc_sel, core_mem_sel}), 64'b10);
    check("core_addr", 64'(core_addr), 64'h40);
    check("core_data_in", core_data_in, 64'h1122_3344_5566_7788);
    check("core_key", 64'(core_key === key_exp), 64'd1);

    // W two cycles ahead of AW, bready held low
    wdata = 64'h1234; wstrb = 8'hFF; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); @(negedge clk); wvalid = 1'b0;
    @(posedge clk); @(negedge clk);
    awaddr = 16'h10; awvalid = 1'b1;
    @(posedge clk); @(negedge clk); awvalid = 1'b0;
    @(posedge clk); @(negedge clk);
    awaddr = 16'h18; wdata = 64'hBAD; awvalid = 1'b1; wvalid = 1'b1;
    hold = 0; acc = 0;
    for (int i = 0; i < 4; i++) begin
      if (bvalid) hold++;
      if (awready || wready) acc++;
      @(posedge clk); @(negedge clk);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid_held", 64'(hold), 64'd4);
    check("no_accept_during_b", 64'(acc), 64'd0);
    check("late_aw_bresp", 64'({bvalid, bresp}), 64'b100);
    bready = 1'b1;
    @(posedge clk); @(negedge clk); bready = 1'b0;
    check("bvalid_released", 64'(bvalid), 64'd0);
    axi_read(16'h10, rd, resp);
    check("caddr_late_aw", rd, 64'h1234);
    axi_read(16'h18, rd, resp);
    check("din_untouched", rd, 64'h1122_3344_5566_7788);

    // RO / unmapped accesses
    axi_write(16'h20, 64'h1, 8'hFF, resp);
    check("wr_ro_slverr", 64'(resp), 64'd2);
    axi_write(16'hA0, 64'h1, 8'hFF, resp);
    check("wr_unmapped_slverr", 64'(resp), 64'd2);
    axi_read(16'hA0, rd, resp);
    check("rd_unmapped_data", rd, 64'h0);
    check("rd_unmapped_resp", 64'(resp), 64'd2);
    axi_read(16'h20, rd, resp);
    check("data_out_unchanged", rd, CORE_VAL);
    axi_read(16'h78, rd, resp);
    check("last_key_word", {rd[61:0], resp}, {62'd7, 2'b00});
    axi_read(16'h80, rd, resp);
    check("past_key_slverr", 64'(resp), 64'd2);

    // Byte strobes
    axi_write(16'h18, 64'h0, 8'hFF, resp);
    axi_write(16'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, resp);
    axi_read(16'h18, rd, resp);
    check("wstrb_low_half", rd, 64'h0000_0000_FFFF_FFFF);

    // Writes landing while busy, error captured
    p0 = start_pulses;
    axi_write(16'h00, 64'h1, 8'hFF, resp);
    axi_write(16'h18, 64'h5555, 8'hFF, resp);
    check("din_busy_slverr", 64'(resp), 64'd2);
    axi_read(16'h18, rd, resp);
    check("din_busy_unchanged", rd, 64'h0000_0000_FFFF_FFFF);
    core_error = 1'b1;
    axi_write(16'h00, 64'hB, 8'hFF, resp);
    axi_write(16'h00, 64'h1, 8'hFF, resp);
    check("start_capture_cycle_slverr", 64'(resp), 64'd2);
    axi_read(16'h08, rd, resp);
    check("status_err_done", rd, 64'h6);
    repeat (4) @(negedge clk);
    check("busy_start_ignored", 64'(start_pulses - p0), 64'd2);

    // Reset in the second RUN cycle
    core_error = 1'b0;
    axi_write(16'h00, 64'hB, 8'hFF, resp);
    rst = 1'b0;
    #1;
    check("abort_outputs", 64'({core_start, irq, bvalid, rvalid, awready, core_enc_sel}), 64'd0);
    check("abort_core_regs", 64'(core_addr) | core_data_in | 64'(core_key != 512'd0), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    axi_read(16'h08, rd, resp);
    check("abort_status", rd, 64'h0);
    axi_read(16'h20, rd, resp);
    check("abort_data_out", rd, 64'h0);
    axi_write(16'h00, 64'h9, 8'hFF, resp);
    check("restart_resp", 64'(resp), 64'd0);
    repeat (4) @(negedge clk);
    axi_read(16'h08, rd, resp);
    check("restart_status", rd, 64'h2);
    axi_read(16'h20, rd, resp);
    check("restart_data_out", rd, CORE_VAL);
    check("restart_irq", 64'(irq), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
